imem_loader: RTL and testbench

//  Boot-time writer for the 32-bit instruction memory: receives a byte stream (UART/debug link),

---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_loader_byte_packer.sv | 55 +++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// State decode helpers keep the registered output flags consistent with the FSM.
package imem_loader_pkg;

    localparam int HDR_BYTES = 2;
    localparam int COUNT_W   = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } ldr_state_t;

    function automatic logic is_rx_state(input ldr_state_t s);
        logic r;
        case (s)
            LEN0, LEN1, DATA: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

    // FLUSH keeps the core held until the final word has been written.
    function automatic logic is_busy_state(input ldr_state_t s);
        logic r;
        case (s)
            LEN0, LEN1, DATA, FLUSH: r = 1'b1;
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into DATA_WIDTH words; word_valid is
// combinational on the final byte so the top can register the write next cycle.
module byte_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BPW = DATA_WIDTH / 8;

    generate
        if (BPW == 1) begin : g_single
            assign word       = byte_data;
            assign word_valid = byte_valid;
        end else begin : g_multi
            localparam int LW = $clog2(BPW);
            localparam int SW = DATA_WIDTH - 8;

            logic [LW-1:0] lane_r;
            logic [SW-1:0] shift_r;
            logic [SW-1:0] shift_next_s;

            // Earlier bytes shift down so byte k ends up in lane k of the word.
            if (SW == 8) begin : g_two
                assign shift_next_s = byte_data;
            end else begin : g_wide
                assign shift_next_s = {byte_data, shift_r[SW-1:8]};
            end

            assign word_valid = byte_valid & (lane_r == LW'(BPW - 1));
            assign word       = {byte_data, shift_r};

            // Lane counter and partial-word shift register
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    lane_r  <= '0;
                    shift_r <= '0;
                end else if (clear) begin
                    lane_r  <= '0;
                    shift_r <= '0;
                end else if (byte_valid) begin
                    lane_r  <= word_valid ? LW'(0) : lane_r + LW'(1);
                    shift_r <= shift_next_s;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: parses a 16-bit word-count header, then streams packed
// words to a sequential write port while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 1024,
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  we,
    output logic [AW-1:0]         waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [COUNT_W:0] DEPTH_C = (COUNT_W + 1)'(MEM_DEPTH);

    ldr_state_t            state_r;
    ldr_state_t            state_s;
    logic [7:0]            len_lo_r;
    logic [COUNT_W-1:0]    count_r;
    logic [COUNT_W-1:0]    len_s;
    logic [AW-1:0]         word_idx_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  hs_s;
    logic                  load_start_s;
    logic                  pack_valid_s;
    logic                  word_valid_s;
    logic                  last_word_s;
    logic                  len_zero_s;
    logic                  len_over_s;

    assign hs_s         = s_valid & s_ready;
    assign len_s        = {s_data, len_lo_r};
    assign len_zero_s   = (len_s == COUNT_W'(0));
    assign len_over_s   = ({1'b0, len_s} > DEPTH_C);
    assign pack_valid_s = hs_s & (state_r == DATA);
    assign last_word_s  = (COUNT_W'(word_idx_r) == (count_r - COUNT_W'(1)));
    assign core_hold    = busy;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_start_s),
        .byte_data  (s_data),
        .byte_valid (pack_valid_s),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state logic; start only takes effect from the idle-like states
    always_comb begin
        state_s      = state_r;
        load_start_s = 1'b0;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_s      = LEN0;
                    load_start_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            LEN0: begin
                if (hs_s) state_s = LEN1;
                else      state_s = LEN0;
            end
            LEN1: begin
                if (!hs_s)          state_s = LEN1;
                else if (len_zero_s) state_s = DONE;
                else if (len_over_s) state_s = ERR;
                else                 state_s = DATA;
            end
            DATA: begin
                if (word_valid_s && last_word_s) state_s = FLUSH;
                else                             state_s = DATA;
            end
            FLUSH:   state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // State register and status flags decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state_r <= state_s;
            s_ready <= is_rx_state(state_s);
            busy    <= is_busy_state(state_s);
            done    <= (state_s == DONE);
            error   <= (state_s == ERR);
        end
    end

    // Header capture, word index and IMEM write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_lo_r   <= 8'd0;
            count_r    <= '0;
            word_idx_r <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            we <= word_valid_s;
            if (word_valid_s) begin
                waddr <= word_idx_r;
                wdata <= word_s;
            end
            if (load_start_s) begin
                word_idx_r <= '0;
            end else if (word_valid_s) begin
                word_idx_r <= word_idx_r + AW'(1);
            end
            if (hs_s && (state_r == LEN0)) begin
                len_lo_r <= s_data;
            end
            if (hs_s && (state_r == LEN1)) begin
                count_r <= len_s;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: header framing, packing,
// stalls, empty/oversized images, full-depth load, reset mid-load and start races.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int          wr_total = 0;
    int          wr_cnt [1024];
    logic [31:0] wr_mem [1024];
    int          base_cnt [1024];

    imem_loader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    // Write-port monitor: records every IMEM write strobe
    always @(negedge clock) begin
        if (we === 1'b1) begin
            wr_total++;
            wr_cnt[waddr]++;
            wr_mem[waddr] = wdata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Presents one byte at a negedge and returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n       = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
        end else begin
            @(negedge clock);
            s_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic send_slow(input logic [7:0] b);
        send_byte(b);
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [31:0] tb_word(input int w);
        logic [9:0] a;
        a = 10'(w);
        return {8'h5A, 6'd0, a, a[7:0] ^ 8'hFF};
    endfunction

    initial begin
        int base;
        int bad;
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: basic two-word image
        base = wr_total;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_core_hold", 32'(core_hold), 32'd1);
        check("t1_s_ready", 32'(s_ready), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h0000_0013);
        check("t1_we0", 32'(we), 32'd1);
        check("t1_waddr0", 32'(waddr), 32'd0);
        check("t1_wdata0", wdata, 32'h0000_0013);
        send_word(32'h0010_0093);
        check("t1_we1", 32'(we), 32'd1);
        check("t1_waddr1", 32'(waddr), 32'd1);
        check("t1_wdata1", wdata, 32'h0010_0093);
        check("t1_done_early", 32'(done), 32'd0);
        @(negedge clock);
        check("t1_done", 32'(done), 32'd1);
        check("t1_we_off", 32'(we), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_hold_off", 32'(core_hold), 32'd0);
        check("t1_s_ready_off", 32'(s_ready), 32'd0);
        #1;
        check("t1_we_count", 32'(wr_total - base), 32'd2);

        // 2: same image with s_valid high one cycle in three
        base        = wr_total;
        base_cnt[0] = wr_cnt[0];
        base_cnt[1] = wr_cnt[1];
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        send_slow(8'h02);
        send_slow(8'h00);
        send_slow(8'h13); send_slow(8'h00); send_slow(8'h00); send_slow(8'h00);
        send_slow(8'h93); send_slow(8'h00); send_slow(8'h10); send_slow(8'h00);
        #1;
        check("t2_we_count", 32'(wr_total - base), 32'd2);
        check("t2_addr0_once", 32'(wr_cnt[0] - base_cnt[0]), 32'd1);
        check("t2_addr1_once", 32'(wr_cnt[1] - base_cnt[1]), 32'd1);
        check("t2_mem0", wr_mem[0], 32'h0000_0013);
        check("t2_mem1", wr_mem[1], 32'h0010_0093);
        check("t2_done", 32'(done), 32'd1);

        // 3a: empty image
        base = wr_total;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clock);
        check("t3_zero_done", 32'(done), 32'd1);
        check("t3_zero_busy", 32'(busy), 32'd0);
        #1;
        check("t3_zero_writes", 32'(wr_total - base), 32'd0);

        // 3b: N = 1025 is rejected, then a fresh start recovers
        @(negedge clock);
        base = wr_total;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        @(negedge clock);
        check("t3_err", 32'(error), 32'd1);
        check("t3_err_s_ready", 32'(s_ready), 32'd0);
        check("t3_err_done", 32'(done), 32'd0);
        #1;
        check("t3_err_writes", 32'(wr_total - base), 32'd0);
        @(negedge clock);
        pulse_start();
        check("t3_err_cleared", 32'(error), 32'd0);
        check("t3_restart_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        check("t3_rec_we", 32'(we), 32'd1);
        check("t3_rec_waddr", 32'(waddr), 32'd0);
        check("t3_rec_wdata", wdata, 32'hDEAD_BEEF);
        @(negedge clock);
        check("t3_rec_done", 32'(done), 32'd1);

        // 4: full-depth image, every address written exactly once
        for (int a = 0; a < 1024; a++) base_cnt[a] = wr_cnt[a];
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int w = 0; w < 1024; w++) send_word(tb_word(w));
        check("t4_last_we", 32'(we), 32'd1);
        check("t4_last_waddr", 32'(waddr), 32'd1023);
        check("t4_last_wdata", wdata, tb_word(1023));
        @(negedge clock);
        check("t4_done", 32'(done), 32'd1);
        #1;
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            if ((wr_cnt[a] - base_cnt[a]) != 1 || wr_mem[a] !== tb_word(a)) bad++;
        end
        check("t4_bad_addrs", 32'(bad), 32'd0);

        // 5: reset in the middle of word 5
        @(negedge clock);
        pulse_start();
        send_byte(8'h08);
        send_byte(8'h00);
        for (int w = 0; w < 5; w++) send_word(32'hC0DE_0000 | 32'(w));
        send_byte(8'hAA);
        send_byte(8'hBB);
        base  = wr_total;
        reset = 1'b1;
        #1;
        check("t5_s_ready", 32'(s_ready), 32'd0);
        check("t5_we", 32'(we), 32'd0);
        check("t5_waddr", 32'(waddr), 32'd0);
        check("t5_wdata", wdata, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_core_hold", 32'(core_hold), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_error", 32'(error), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("t5_no_extra_writes", 32'(wr_total - base), 32'd0);
        check("t5_mem4", wr_mem[4], 32'hC0DE_0004);
        @(negedge clock);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h0BAD_F00D);
        check("t5_re_waddr", 32'(waddr), 32'd0);
        check("t5_re_wdata", wdata, 32'h0BAD_F00D);
        @(negedge clock);
        check("t5_re_done", 32'(done), 32'd1);

        // 6: start during DATA is ignored; start racing a byte in DONE wins
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        pulse_start();
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_s_ready", 32'(s_ready), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        check("t6_waddr0", 32'(waddr), 32'd0);
        check("t6_wdata0", wdata, 32'h0000_0013);
        send_word(32'h0010_0093);
        check("t6_waddr1", 32'(waddr), 32'd1);
        check("t6_wdata1", wdata, 32'h0010_0093);
        @(negedge clock);
        check("t6_done", 32'(done), 32'd1);
        s_data  = 8'h55;
        s_valid = 1'b1;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        s_valid = 1'b0;
        check("t6_race_s_ready", 32'(s_ready), 32'd1);
        check("t6_race_busy", 32'(busy), 32'd1);
        check("t6_race_done", 32'(done), 32'd0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h1122_3344);
        check("t6_race_we", 32'(we), 32'd1);
        check("t6_race_waddr", 32'(waddr), 32'd0);
        check("t6_race_wdata", wdata, 32'h1122_3344);
        @(negedge clock);
        check("t6_race_fin", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
